// File: rtl/multicycle_controller_if.sv
// Handshake and datapath-control bundle between the multicycle controller (master)
// and the fetch unit / register file / ALU / data memory (slave).
interface multicycle_controller_if #(
  parameter int REG_AW = 4,
  parameter int CMD_W  = 5
);
  logic              instr_valid;
  logic [31:0]       IR_in;
  logic [3:0]        Flags_in;
  logic              dmem_ready;

  logic              instr_ready;
  logic              Wen_ARd;
  logic              Wen_Dmem;
  logic              Wen_Flags;
  logic [CMD_W-1:0]  cmd;
  logic              select_X;
  logic              select_Y;
  logic [1:0]        select_src1;
  logic [2:0]        select_src2shift;
  logic [REG_AW-1:0] rd_addr;
  logic [REG_AW-1:0] rn_addr;
  logic [REG_AW-1:0] rm_addr;
  logic              dmem_req;
  logic              pc_inc;
  logic [3:0]        flags_q;
  logic              fault;

  modport master (
    input  instr_valid, IR_in, Flags_in, dmem_ready,
    output instr_ready, Wen_ARd, Wen_Dmem, Wen_Flags, cmd, select_X, select_Y,
           select_src1, select_src2shift, rd_addr, rn_addr, rm_addr,
           dmem_req, pc_inc, flags_q, fault
  );

  modport slave (
    output instr_valid, IR_in, Flags_in, dmem_ready,
    input  instr_ready, Wen_ARd, Wen_Dmem, Wen_Flags, cmd, select_X, select_Y,
           select_src1, select_src2shift, rd_addr, rn_addr, rm_addr,
           dmem_req, pc_inc, flags_q, fault
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset controller: FETCH/DECODE/EXEC/MEM/WB sequencing, NZCV register,
// condition evaluation and memory handshakes. Optional macro BRANCH_LINK_EN adds BL link writes.
module multicycle_controller #(
  parameter int REG_AW   = 4,
  parameter int CMD_W    = 5,
  parameter int MAX_WAIT = 15
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  multicycle_controller_if.master bus
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;

  state_t      state;
  logic [31:20] ir_q;
  logic [7:0]  wait_cnt;
  logic        str_q;
  logic        unused_ir;

  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0:    cond_pass = z;
      4'h1:    cond_pass = !z;
      4'h2:    cond_pass = cy;
      4'h3:    cond_pass = !cy;
      4'h4:    cond_pass = n;
      4'h5:    cond_pass = !n;
      4'h6:    cond_pass = v;
      4'h7:    cond_pass = !v;
      4'h8:    cond_pass = cy && !z;
      4'h9:    cond_pass = !cy || z;
      4'hA:    cond_pass = (n == v);
      4'hB:    cond_pass = (n != v);
      4'hC:    cond_pass = !z && (n == v);
      4'hD:    cond_pass = z || (n != v);
      4'hE:    cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  // Only IR[31:20] steers sequencing; the register fields are captured straight into the address outputs.
  assign unused_ir = ^bus.IR_in;

  // A store writes exactly on the cycle memory accepts it, so the enable follows dmem_ready directly.
  assign bus.Wen_Dmem = str_q & bus.dmem_req & bus.dmem_ready & ~reset;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state                <= FETCH;
      wait_cnt             <= '0;
      str_q                <= 1'b0;
      bus.instr_ready      <= 1'b0;
      bus.Wen_ARd          <= 1'b0;
      bus.Wen_Flags        <= 1'b0;
      bus.cmd              <= '0;
      bus.select_X         <= 1'b0;
      bus.select_Y         <= 1'b0;
      bus.select_src1      <= 2'b00;
      bus.select_src2shift <= 3'b000;
      bus.rd_addr          <= '0;
      bus.rn_addr          <= '0;
      bus.rm_addr          <= '0;
      bus.dmem_req         <= 1'b0;
      bus.pc_inc           <= 1'b0;
      bus.flags_q          <= 4'b0000;
      bus.fault            <= 1'b0;
    end else begin
      bus.Wen_ARd   <= 1'b0;
      bus.Wen_Flags <= 1'b0;
      bus.pc_inc    <= 1'b0;
      bus.select_X  <= 1'b0;
      bus.select_Y  <= 1'b0;
      unique case (state)
        FETCH: begin
          bus.instr_ready <= 1'b1;
          if (bus.instr_ready && bus.instr_valid) begin
            ir_q            <= bus.IR_in[31:20];
            bus.rd_addr     <= bus.IR_in[12 +: REG_AW];
            bus.rn_addr     <= bus.IR_in[16 +: REG_AW];
            bus.rm_addr     <= bus.IR_in[0 +: REG_AW];
            bus.instr_ready <= 1'b0;
            state           <= DECODE;
          end
        end
        DECODE: begin
          if (ir_q[27:26] == 2'b11) begin
            bus.fault       <= 1'b1;
            bus.pc_inc      <= 1'b1;
            bus.instr_ready <= 1'b1;
            state           <= FETCH;
          end else if (!cond_pass(ir_q[31:28], bus.flags_q)) begin
            bus.pc_inc      <= 1'b1;
            bus.instr_ready <= 1'b1;
            state           <= FETCH;
          end else begin
            state <= EXEC;
            case (ir_q[27:26])
              2'b00: begin
                bus.cmd              <= CMD_W'(ir_q[24:21]);
                bus.select_src2shift <= ir_q[25] ? 3'b001 : 3'b000;
                bus.Wen_ARd          <= 1'b1;
                bus.Wen_Flags        <= ir_q[20];
                bus.pc_inc           <= 1'b1;
              end
              2'b01: begin
                bus.cmd              <= CMD_W'(4'b0100);
                bus.select_src2shift <= ir_q[25] ? 3'b011 : 3'b010;
              end
              default: begin
                bus.cmd              <= CMD_W'(4'b0100);
                bus.select_src1      <= 2'b10;
                bus.select_src2shift <= 3'b101;
                bus.select_Y         <= 1'b1;
`ifdef BRANCH_LINK_EN
                if (ir_q[24]) begin
                  bus.Wen_ARd <= 1'b1;
                  bus.rd_addr <= {{(REG_AW-1){1'b1}}, 1'b0};
                end
`endif
              end
            endcase
          end
        end
        EXEC: begin
          if (bus.Wen_Flags) bus.flags_q <= bus.Flags_in;
          if (ir_q[27:26] == 2'b01) begin
            bus.dmem_req <= 1'b1;
            wait_cnt     <= '0;
            str_q        <= ~ir_q[20];
            state        <= MEM;
          end else begin
            bus.cmd              <= '0;
            bus.select_src1      <= 2'b00;
            bus.select_src2shift <= 3'b000;
            bus.instr_ready      <= 1'b1;
            state                <= FETCH;
          end
        end
        MEM: begin
          // dmem_ready on the last allowed wait cycle still completes the access.
          if (bus.dmem_ready || wait_cnt == 8'(MAX_WAIT - 1)) begin
            bus.dmem_req         <= 1'b0;
            str_q                <= 1'b0;
            bus.cmd              <= '0;
            bus.select_src1      <= 2'b00;
            bus.select_src2shift <= 3'b000;
            bus.pc_inc           <= 1'b1;
            if (bus.dmem_ready && !str_q) begin
              bus.select_X <= 1'b1;
              bus.Wen_ARd  <= 1'b1;
              state        <= WB;
            end else begin
              if (!bus.dmem_ready) bus.fault <= 1'b1;
              bus.instr_ready <= 1'b1;
              state           <= FETCH;
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        WB: begin
          bus.instr_ready <= 1'b1;
          state           <= FETCH;
        end
        default: begin
          bus.instr_ready <= 1'b1;
          state           <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomised self-checking bench for multicycle_controller against an instruction-level model.
module tb_multicycle_controller;
  localparam int REG_AW = 4;
  localparam int CMD_W  = 5;
  localparam int MW     = 6;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;
  always #5 CLOCK_50 = ~CLOCK_50;

  multicycle_controller_if #(.REG_AW(REG_AW), .CMD_W(CMD_W)) bus ();
  multicycle_controller #(.REG_AW(REG_AW), .CMD_W(CMD_W), .MAX_WAIT(MW)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .bus(bus));

  int n_total = 0;
  int n_pass  = 0;
  logic [3:0] m_flags = 4'b0000;
  logic       m_fault = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return (c[0] == 1'b0);
    endcase
    return c[0] ? !base : base;
  endfunction

  function automatic logic [63:0] all_outs();
    return {29'd0, bus.instr_ready, bus.Wen_ARd, bus.Wen_Dmem, bus.Wen_Flags, bus.cmd,
            bus.select_X, bus.select_Y, bus.select_src1, bus.select_src2shift,
            bus.rd_addr, bus.rn_addr, bus.rm_addr, bus.dmem_req, bus.pc_inc,
            bus.flags_q, bus.fault};
  endfunction

  task automatic do_reset();
    reset = 1'b1; bus.instr_valid = 1'b0; bus.dmem_ready = 1'b0;
    @(negedge CLOCK_50); @(negedge CLOCK_50);
    chk("reset_outs", all_outs(), 64'd0);
    reset = 1'b0;
    m_flags = 4'b0000; m_fault = 1'b0;
  endtask

  // rdly: MEM cycle (1-based) on which dmem_ready rises; anything above MW means never.
  task automatic run_instr(input logic [31:0] ir, input logic [3:0] fin, input int rdly, input bit junk);
    int guard, busy, req, ard, flg, dme, dbad, pci, sely, selx;
    int e_busy, e_ard, e_flg, e_dme, e_pci, e_sely, e_selx, e_req, e_cmd, e_src1, e_src2, e_rd;
    bit pass, done;
    logic [1:0] cls;
    logic [63:0] c_cmd, c_src1, c_src2, c_addr;

    guard = 0;
    while (!bus.instr_ready && guard < 20) begin @(negedge CLOCK_50); #1; guard++; end
    chk("fetch_ready", bus.instr_ready, 1'b1);
    if (!bus.instr_ready) return;

    cls = ir[27:26];
    pass = (cls != 2'b11) && cond_ok(ir[31:28], m_flags);
    {e_busy, e_ard, e_flg, e_dme, e_pci, e_sely, e_selx, e_req} = '0;
    e_cmd = 4; e_src1 = 0; e_src2 = 0; e_rd = ir[15:12];
    if (!pass) begin
      e_busy = 1; e_pci = 1;
      if (cls == 2'b11) m_fault = 1'b1;
    end else if (cls == 2'b00) begin
      e_busy = 2; e_ard = 1; e_flg = ir[20]; e_pci = 1; e_cmd = ir[24:21]; e_src2 = ir[25] ? 1 : 0;
    end else if (cls == 2'b01) begin
      e_src2 = ir[25] ? 3 : 2; e_pci = 1;
      if (rdly >= 1 && rdly <= MW) begin
        e_req = rdly;
        if (ir[20]) begin e_busy = 3 + rdly; e_ard = 1; e_selx = 1; end
        else begin e_busy = 2 + rdly; e_dme = 1; end
      end else begin
        e_req = MW; e_busy = 2 + MW; m_fault = 1'b1;
      end
    end else begin
      e_busy = 2; e_sely = 1; e_src1 = 2; e_src2 = 5;
`ifdef BRANCH_LINK_EN
      if (ir[24]) begin e_ard = 1; e_rd = (1 << REG_AW) - 2; end
`endif
    end

    bus.IR_in = ir; bus.instr_valid = 1'b1; bus.Flags_in = fin;
    {busy, req, ard, flg, dme, dbad, pci, sely, selx} = '0;
    {c_cmd, c_src1, c_src2, c_addr} = '0;
    done = 1'b0;
    while (!done) begin
      @(negedge CLOCK_50);
      if (bus.instr_ready) done = 1'b1;
      else busy++;
      bus.instr_valid = (junk && !done) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (junk) bus.IR_in = $urandom;
      if (bus.dmem_req) begin req++; bus.dmem_ready = (req == rdly); end
      else bus.dmem_ready = 1'b0;
      #1;
      ard += bus.Wen_ARd; flg += bus.Wen_Flags; pci += bus.pc_inc;
      sely += bus.select_Y; selx += bus.select_X; dme += bus.Wen_Dmem;
      dbad += (bus.Wen_Dmem && !bus.dmem_ready);
      if (busy == 2 && !done) begin
        c_cmd = bus.cmd; c_src1 = bus.select_src1; c_src2 = bus.select_src2shift;
        c_addr = {bus.rd_addr, bus.rn_addr, bus.rm_addr};
      end
      if (busy > 60) begin chk("hang", busy, e_busy); done = 1'b1; end
    end
    bus.dmem_ready = 1'b0;
    if (pass && cls == 2'b00 && ir[20]) m_flags = fin;

    chk("busy_cycles", busy, e_busy);
    chk("wen_ard", ard, e_ard);
    chk("wen_flags", flg, e_flg);
    chk("wen_dmem", dme, e_dme);
    chk("wen_dmem_no_ready", dbad, 0);
    chk("pc_inc", pci, e_pci);
    chk("select_y", sely, e_sely);
    chk("select_x", selx, e_selx);
    chk("dmem_req_cycles", req, e_req);
    chk("flags_q", bus.flags_q, m_flags);
    chk("fault", bus.fault, m_fault);
    if (pass) begin
      chk("exec_cmd", c_cmd, e_cmd);
      chk("exec_src1", c_src1, e_src1);
      chk("exec_src2shift", c_src2, e_src2);
      chk("exec_addrs", c_addr, {e_rd[3:0], ir[19:16], ir[3:0]});
    end
  endtask

  initial begin
    logic [31:0] ir;
    int rdly;
    bus.instr_valid = 1'b0; bus.IR_in = '0; bus.Flags_in = '0; bus.dmem_ready = 1'b0;
    do_reset();

    run_instr(32'hE0810312, 4'b0000, 0, 1'b0);
    run_instr(32'hE0910002, 4'b0100, 0, 1'b0);
    run_instr(32'h02510002, 4'b0010, 0, 1'b0);
    run_instr(32'h12420002, 4'b0000, 0, 1'b0);
    run_instr(32'hE0910002, 4'b0100, 0, 1'b0);
    run_instr(32'h12420002, 4'b1111, 0, 1'b0);
    run_instr(32'h06010012, 4'b0000, 3, 1'b0);
    run_instr(32'h04110003, 4'b0000, 2, 1'b0);
    run_instr(32'h04110003, 4'b0000, MW, 1'b0);
    run_instr(32'h04110003, 4'b0000, MW + 1, 1'b0);
    run_instr(32'hE0810312, 4'b0000, 0, 1'b0);
    do_reset();
    run_instr(32'hE0910002, 4'b0010, 0, 1'b0);
    run_instr(32'h8A000008, 4'b0000, 0, 1'b0);
    run_instr(32'hEB000004, 4'b0000, 0, 1'b0);
    run_instr(32'hE0910002, 4'b0000, 0, 1'b0);
    run_instr(32'h8A000008, 4'b0000, 0, 1'b0);
    run_instr(32'hFE000000, 4'b0000, 0, 1'b0);
    run_instr(32'hEC000000, 4'b0000, 0, 1'b0);

    // Reset while an LDR waits in MEM.
    while (!bus.instr_ready) @(negedge CLOCK_50);
    bus.IR_in = 32'hE4110003; bus.instr_valid = 1'b1;
    @(negedge CLOCK_50); bus.instr_valid = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    chk("mem_req_before_reset", bus.dmem_req, 1'b1);
    reset = 1'b1; bus.dmem_ready = 1'b1;
    #1;
    chk("wen_dmem_in_reset", bus.Wen_Dmem, 1'b0);
    @(negedge CLOCK_50);
    chk("reset_in_mem_outs", all_outs(), 64'd0);
    reset = 1'b0; bus.dmem_ready = 1'b0;
    m_flags = 4'b0000; m_fault = 1'b0;

    for (int i = 0; i < 150; i++) begin
      ir = $urandom;
      if ($urandom_range(0, 2) == 0) ir[31:28] = 4'hE;
      ir[27:26] = ($urandom_range(0, 24) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      rdly = $urandom_range(1, MW + 1);
      run_instr(ir, 4'($urandom_range(0, 15)), rdly, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
